// File: rtl/dmem_pkg.sv
// Shared widths and FSM state type for the data block memory.
package dmem_pkg;

    localparam int BLOCK_W      = 128;
    localparam int BLOCK_ADDR_W = 28;
    localparam int WORD_W       = 32;
    localparam int CNT_W        = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_block_array.sv
// Block storage: one synchronous write port, one registered read port.
// Contents have no reset so they survive a controller reset.
module dmem_block_array
    import dmem_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_addr,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [INDEX_W-1:0] rd_addr,
    output logic [BLOCK_W-1:0] rd_data
);

    logic [BLOCK_W-1:0] mem [2**INDEX_W];

    // Write commits and read sampling both happen on the rising edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/data_block_memory.sv
// Block memory behind the data cache: a request is accepted in IDLE,
// held for ACCESS_LATENCY cycles in ACCESS, and acknowledged in DONE.
//
//   state     | meaning
//   ST_IDLE   | waiting; a single request raises MEM_BUSYWAIT at once
//   ST_ACCESS | counting down; inputs ignored, latched request used
//   ST_DONE   | one cycle with MEM_BUSYWAIT low, then back to IDLE
module data_block_memory
    import dmem_pkg::*;
#(
    parameter int ACCESS_LATENCY = 5,
    parameter int INDEX_W        = 8
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    MEM_READ,
    input  logic                    MEM_WRITE,
    input  logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]      MEM_WRITEDATA,
    output logic [BLOCK_W-1:0]      MEM_READDATA,
    output logic                    MEM_BUSYWAIT,
    output logic                    PROTO_ERR
);

    dmem_state_t        state_q, state_d;
    logic               op_write_q;
    logic [INDEX_W-1:0] idx_q;
    logic [BLOCK_W-1:0] wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BLOCK_W-1:0] readdata_q;
    logic               proto_err_q;
    logic               busy;

    logic               req_one;
    logic               req_both;
    logic               arr_wr_en;
    logic [INDEX_W-1:0] arr_rd_addr;
    logic [BLOCK_W-1:0] arr_rd_data;

    // Upper address bits alias onto the indexed blocks and are not decoded.
    logic unused_addr_hi;
    assign unused_addr_hi = ^MEM_ADDRESS[BLOCK_ADDR_W-1:INDEX_W];

    assign req_one  = MEM_READ ^ MEM_WRITE;
    assign req_both = MEM_READ & MEM_WRITE;

    // In IDLE the read port looks at the incoming address so that the array
    // output is already valid after the accepting edge (needed for latency 1).
    assign arr_rd_addr = (state_q == ST_IDLE) ? MEM_ADDRESS[INDEX_W-1:0] : idx_q;
    assign arr_wr_en   = (state_q == ST_ACCESS) && (cnt_q == '0) && op_write_q;

    dmem_block_array #(
        .INDEX_W (INDEX_W)
    ) u_array (
        .clk     (CLOCK),
        .wr_en   (arr_wr_en),
        .wr_addr (idx_q),
        .wr_data (wdata_q),
        .rd_addr (arr_rd_addr),
        .rd_data (arr_rd_data)
    );

    // State register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and busy indication; busy is forced low while reset is held.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = RESET & req_one;
                if (req_one) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request latch, latency counter, read data and protocol error flag.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            op_write_q  <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            readdata_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_one) begin
                        op_write_q <= MEM_WRITE;
                        idx_q      <= MEM_ADDRESS[INDEX_W-1:0];
                        wdata_q    <= MEM_WRITEDATA;
                        cnt_q      <= CNT_W'(ACCESS_LATENCY - 1);
                    end else if (req_both) begin
                        proto_err_q <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (!op_write_q) begin
                            readdata_q <= arr_rd_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign MEM_READDATA = readdata_q;
    assign MEM_BUSYWAIT = busy;
    assign PROTO_ERR    = proto_err_q;

endmodule

// File: tb/tb_data_block_memory.sv
// Bench for data_block_memory: a cycle-accounting model predicts busy,
// read data and error flag for the default instance on every cycle;
// directed requests carry hand-computed literal expectations, including a
// second instance built with latency 1 and 16 blocks.
module tb_data_block_memory;

    localparam int LAT1 = 5;
    localparam int IDX1 = 8;
    localparam int LAT2 = 1;
    localparam int IDX2 = 4;

    logic         clk;
    logic         rst_n;
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata1, rdata2;
    logic         busy1, busy2;
    logic         err1, err2;

    int errors = 0;
    int checks = 0;

    data_block_memory #(.ACCESS_LATENCY(LAT1), .INDEX_W(IDX1)) dut1 (
        .CLOCK(clk), .RESET(rst_n), .MEM_READ(rd), .MEM_WRITE(wr),
        .MEM_ADDRESS(addr), .MEM_WRITEDATA(wdata),
        .MEM_READDATA(rdata1), .MEM_BUSYWAIT(busy1), .PROTO_ERR(err1)
    );

    data_block_memory #(.ACCESS_LATENCY(LAT2), .INDEX_W(IDX2)) dut2 (
        .CLOCK(clk), .RESET(rst_n), .MEM_READ(rd), .MEM_WRITE(wr),
        .MEM_ADDRESS(addr), .MEM_WRITEDATA(wdata),
        .MEM_READDATA(rdata2), .MEM_BUSYWAIT(busy2), .PROTO_ERR(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- cycle-accounting model for dut1 ----------------
    // A request accepted in cycle t keeps busy high for cycles t..t+LAT,
    // its effect is visible from cycle t+LAT+1, and the next request can be
    // taken from cycle t+LAT+2.
    int           cyc = 0;
    int           free_at = 0;
    int           t_acc = 0;
    bit           in_txn = 0;
    bit           t_wr = 0;
    int           t_idx = 0;
    logic [127:0] t_data = '0;
    logic [127:0] m_rd = '0;
    bit           m_rd_known = 1;
    bit           m_err = 0;
    logic [127:0] mem_model [int];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        bit exp_busy;
        if (!rst_n) begin
            m_rd       = '0;
            m_rd_known = 1;
            m_err      = 0;
            in_txn     = 0;
            free_at    = cyc;
            chk("rst_busy", {127'd0, busy1}, 128'd0);
            chk("rst_rdata", rdata1, 128'd0);
            chk("rst_err", {127'd0, err1}, 128'd0);
        end else begin
            if (in_txn && cyc == t_acc + LAT1 + 1) begin
                in_txn = 0;
                if (t_wr) begin
                    mem_model[t_idx] = t_data;
                end else if (mem_model.exists(t_idx)) begin
                    m_rd       = mem_model[t_idx];
                    m_rd_known = 1;
                end else begin
                    m_rd_known = 0;
                end
            end
            exp_busy = in_txn || (cyc >= free_at && (rd ^ wr));
            chk("model_busy", {127'd0, busy1}, {127'd0, exp_busy});
            chk("model_err", {127'd0, err1}, {127'd0, m_err});
            if (m_rd_known) chk("model_rdata", rdata1, m_rd);
            if (!in_txn && cyc >= free_at) begin
                if (rd && wr) begin
                    m_err = 1;
                end else if (rd ^ wr) begin
                    in_txn  = 1;
                    t_acc   = cyc;
                    t_wr    = wr;
                    t_idx   = int'(addr % (1 << IDX1));
                    t_data  = wdata;
                    free_at = cyc + LAT1 + 2;
                end
            end
        end
    end

    // ---------------- directed request driver ----------------
    // Returns the number of consecutive busy cycles seen on the selected
    // instance; on return the bench sits just after the edge into IDLE.
    task automatic do_req(input bit is_wr, input logic [27:0] a, input logic [127:0] d,
                          input bit nowait, input bit hold, input bit scramble,
                          input bit sel2, output int nbusy);
        bit done_seen;
        if (!nowait) begin
            @(posedge clk); #1;
        end
        wr = is_wr; rd = !is_wr; addr = a; wdata = d;
        nbusy = 0;
        done_seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sel2 ? busy2 : busy1) begin
                nbusy++;
                if (scramble && nbusy == 2) begin
                    addr = ~a; wdata = ~d; rd = 1'b0; wr = 1'b0;
                end
            end else begin
                done_seen = 1;
                break;
            end
        end
        if (!done_seen) begin
            errors++;
            $display("FAIL req_timeout: busy still high after 200 cycles");
        end
        @(posedge clk); #1;
        if (!hold) begin
            rd = 1'b0; wr = 1'b0;
        end
    endtask

    localparam logic [127:0] D0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] DA = {4{32'hAAAA_AAAA}};
    localparam logic [127:0] D5 = {4{32'h5555_5555}};
    localparam logic [127:0] D1 = {4{32'h1111_1111}};
    localparam logic [127:0] DF = {4{32'hFFFF_FFFF}};
    localparam logic [127:0] DD = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;

    initial begin
        int nb;
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        #2;
        chk("reset_busy", {127'd0, busy1}, 128'd0);
        chk("reset_rdata", rdata1, 128'd0);
        chk("reset_err", {127'd0, err1}, 128'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // first request in the very first cycle out of reset
        do_req(1, 28'h0000010, D0, 1, 0, 0, 0, nb);
        chk("wr_busy_cycles", 128'(nb), 128'd6);
        do_req(0, 28'h0000010, D0, 0, 0, 0, 0, nb);
        chk("rd_busy_cycles", 128'(nb), 128'd6);
        chk("rd_data_0x10", rdata1, D0);

        // aliasing write, then back-to-back reads with the request held
        do_req(1, 28'h0000105, DA, 0, 0, 0, 0, nb);
        do_req(0, 28'h0000010, 128'd0, 0, 1, 0, 0, nb);
        chk("b2b_first_data", rdata1, D0);
        do_req(0, 28'h0000005, 128'd0, 1, 0, 0, 0, nb);
        chk("b2b_second_busy", 128'(nb), 128'd6);
        chk("alias_data", rdata1, DA);

        // inputs scrambled mid-access: latched request must win
        do_req(1, 28'h0000020, D5, 0, 0, 1, 0, nb);
        chk("scramble_busy", 128'(nb), 128'd6);
        do_req(0, 28'h0000020, 128'd0, 0, 0, 0, 0, nb);
        chk("scramble_data", rdata1, D5);

        // both requests high: rejected, sticky error
        @(posedge clk); #1;
        rd = 1'b1; wr = 1'b1; addr = 28'h0000010; wdata = DF;
        @(negedge clk);
        chk("both_busy", {127'd0, busy1}, 128'd0);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        chk("both_err_set", {127'd0, err1}, 128'd1);
        repeat (3) @(posedge clk);
        #1 chk("both_err_held", {127'd0, err1}, 128'd1);
        do_req(0, 28'h0000010, 128'd0, 0, 0, 0, 0, nb);
        chk("both_no_change", rdata1, D0);

        // reset during the 3rd access cycle of a write aborts it
        do_req(1, 28'h0000030, D1, 0, 0, 0, 0, nb);
        @(posedge clk); #1;
        wr = 1'b1; rd = 1'b0; addr = 28'h0000030; wdata = DF;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0; wr = 1'b0;
        #1;
        chk("abort_busy", {127'd0, busy1}, 128'd0);
        chk("abort_rdata", rdata1, 128'd0);
        chk("abort_err", {127'd0, err1}, 128'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        do_req(0, 28'h0000030, 128'd0, 1, 0, 0, 0, nb);
        chk("abort_retained", rdata1, D1);

        // latency-1 instance with 16 blocks: 2 busy cycles, aliasing index
        repeat (10) @(posedge clk);
        do_req(1, 28'h0000007, DD, 0, 0, 0, 1, nb);
        chk("lat1_wr_busy", 128'(nb), 128'd2);
        do_req(0, 28'h0000017, 128'd0, 0, 0, 0, 1, nb);
        chk("lat1_rd_busy", 128'(nb), 128'd2);
        chk("lat1_rd_data", rdata2, DD);

        repeat (10) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
